// File: rtl/usb_tx_sched_pkg.sv
// Shared constants and helpers for the USB transmit wire scheduler.
// State encodings stay as plain 2-bit constants so older consumers can reuse them.
package usb_tx_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Ceiling log2, floored at 1 so the result can always size a vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/usb_rr_pick.sv
// Combinational pick for a mixed strict-priority / round-robin arbiter.
// Priority-class requesters win by lowest index; others rotate from rrPtr+1.
module usb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [N-1:0]  hipriMask,
  input  logic [IW-1:0] rrPtr,
  output logic          valid,
  output logic [IW-1:0] pick,
  output logic          isHipri
);

  logic [N-1:0] hp;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % N);
  endfunction

  // Later loop iterations overwrite earlier ones, so the descending scans keep the nearest hit.
  always_comb begin
    hp      = eligible & hipriMask;
    valid   = |eligible;
    isHipri = |hp;
    pick    = '0;
    if (isHipri) begin
      for (int i = N - 1; i >= 0; i--) begin
        pick = hp[IW'(i)] ? IW'(i) : pick;
      end
    end else begin
      for (int off = N; off >= 1; off--) begin
        pick = eligible[wrap_idx(int'(rrPtr) + off)] ? wrap_idx(int'(rrPtr) + off) : pick;
      end
    end
  end

endmodule

// File: rtl/usb_tx_wire_sched.sv
// Shares one USB transmit wire between NUM_REQ sources with priority/RR arbitration,
// a forced idle gap between owners and a hold watchdog that locks out a hung owner.
module usb_tx_wire_sched
  import usb_tx_sched_pkg::*;
#(
  parameter int                 NUM_REQ    = 4,
  parameter logic [NUM_REQ-1:0] HIPRI_MASK = 4'b0100,
  parameter int                 GAP_CYCLES = 2,
  parameter int                 MAX_HOLD   = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         reqTxCtl,
  input  logic [2*NUM_REQ-1:0]       reqTxData,
  input  logic [NUM_REQ-1:0]         reqTxFSRate,
  input  logic [NUM_REQ-1:0]         reqTxWEn,
  input  logic                       USBWireRdyIn,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [clog2(NUM_REQ)-1:0]  gntIdx,
  output logic                       busy,
  output logic                       timeoutErr,
  output logic [1:0]                 TxBits,
  output logic                       TxCtl,
  output logic                       TxFSRate,
  output logic                       USBWireWEn,
  output logic                       USBWireRdyOut
);

  localparam int IDX_W  = clog2(NUM_REQ);
  localparam int HOLD_W = clog2(MAX_HOLD + 1);
  localparam int GAP_W  = clog2(GAP_CYCLES + 1);

  logic [1:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   gntIdx_q, gntIdx_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [NUM_REQ-1:0] lockout_q, lockout_d;
  logic [HOLD_W-1:0]  holdCnt_q, holdCnt_d;
  logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
  logic               busy_q, busy_d;
  logic               timeoutErr_q, timeoutErr_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_hipri;
  logic               owner_req;

  usb_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .eligible  (req & ~lockout_q),
    .hipriMask (HIPRI_MASK),
    .rrPtr     (rrPtr_q),
    .valid     (pick_valid),
    .pick      (pick_idx),
    .isHipri   (pick_hipri)
  );

  assign owner_req = req[gntIdx_q];

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gntIdx_d     = gntIdx_q;
    rrPtr_d      = rrPtr_q;
    holdCnt_d    = holdCnt_q;
    gapCnt_d     = gapCnt_q;
    timeoutErr_d = 1'b0;
    lockout_d    = lockout_q & req;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d     = NUM_REQ'(1) << pick_idx;
          gntIdx_d  = pick_idx;
          holdCnt_d = '0;
          state_d   = GRANT;
          rrPtr_d   = pick_hipri ? rrPtr_q : pick_idx;
        end else begin
          gnt_d = '0;
        end
      end
      GRANT: begin
        // A release that coincides with the watchdog limit is a normal release.
        if (!owner_req || (MAX_HOLD != 0 && holdCnt_q == HOLD_W'(MAX_HOLD - 1))) begin
          gnt_d = '0;
          if (owner_req) begin
            timeoutErr_d        = 1'b1;
            lockout_d[gntIdx_q] = 1'b1;
          end else begin
            timeoutErr_d = 1'b0;
          end
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d  = GAP;
            gapCnt_d = GAP_W'(GAP_CYCLES);
          end
        end else begin
          holdCnt_d = (holdCnt_q == {HOLD_W{1'b1}}) ? holdCnt_q : holdCnt_q + HOLD_W'(1);
        end
      end
      GAP: begin
        gnt_d    = '0;
        gapCnt_d = (gapCnt_q == '0) ? gapCnt_q : gapCnt_q - GAP_W'(1);
        // Leave as the count steps to 1 so the IDLE visit completes the gap.
        if (int'(gapCnt_q) <= 2) begin
          state_d = IDLE;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d == GRANT) || (state_d == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gntIdx_q     <= '0;
      rrPtr_q      <= IDX_W'(NUM_REQ - 1);
      lockout_q    <= '0;
      holdCnt_q    <= '0;
      gapCnt_q     <= '0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gntIdx_q     <= gntIdx_d;
      rrPtr_q      <= rrPtr_d;
      lockout_q    <= lockout_d;
      holdCnt_q    <= holdCnt_d;
      gapCnt_q     <= gapCnt_d;
      busy_q       <= busy_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  always_comb begin
    if (|gnt_q) begin
      TxBits     = reqTxData[{gntIdx_q, 1'b0} +: 2];
      TxCtl      = reqTxCtl[gntIdx_q];
      TxFSRate   = reqTxFSRate[gntIdx_q];
      USBWireWEn = reqTxWEn[gntIdx_q];
    end else begin
      TxBits     = 2'b00;
      TxCtl      = 1'b0;
      TxFSRate   = 1'b0;
      USBWireWEn = 1'b0;
    end
  end

  assign gnt           = gnt_q;
  assign gntIdx        = gntIdx_q;
  assign busy          = busy_q;
  assign timeoutErr    = timeoutErr_q;
  assign USBWireRdyOut = USBWireRdyIn;

endmodule

// File: tb/tb_usb_tx_wire_sched.sv
// Scoreboard bench: stimulus queues expected grant owners, a negedge monitor
// checks each new grant and its muxed wire signals; directed checks cover timing.
module tb_usb_tx_wire_sched;

  logic       clk;
  logic       rst;
  logic [3:0] req, req_b;
  logic [1:0] td [4];
  logic [3:0] tctl, tfs, twen;
  logic [7:0] tdata;
  logic       rdy_in;

  logic [3:0] gnt, gnt_b;
  logic [1:0] gntIdx, gntIdx_b;
  logic       busy, busy_b, tmo, tmo_b;
  logic [1:0] txbits, txbits_b;
  logic       txctl, txctl_b, txfs, txfs_b, wen, wen_b, rdy_out, rdy_out_b;

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] sb_q[$];
  logic [1:0] ei;
  logic [3:0] exp_g;
  logic [3:0] prev_gnt = 4'b0000;
  logic [1:0] ord [4];

  assign tdata = {td[3], td[2], td[1], td[0]};

  usb_tx_wire_sched #(.NUM_REQ(4), .HIPRI_MASK(4'b0100), .GAP_CYCLES(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .reqTxCtl(tctl), .reqTxData(tdata),
    .reqTxFSRate(tfs), .reqTxWEn(twen), .USBWireRdyIn(rdy_in),
    .gnt(gnt), .gntIdx(gntIdx), .busy(busy), .timeoutErr(tmo),
    .TxBits(txbits), .TxCtl(txctl), .TxFSRate(txfs), .USBWireWEn(wen),
    .USBWireRdyOut(rdy_out)
  );

  usb_tx_wire_sched #(.NUM_REQ(4), .HIPRI_MASK(4'b0100), .GAP_CYCLES(0), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req_b), .reqTxCtl(tctl), .reqTxData(tdata),
    .reqTxFSRate(tfs), .reqTxWEn(twen), .USBWireRdyIn(rdy_in),
    .gnt(gnt_b), .gntIdx(gntIdx_b), .busy(busy_b), .timeoutErr(tmo_b),
    .TxBits(txbits_b), .TxCtl(txctl_b), .TxFSRate(txfs_b), .USBWireWEn(wen_b),
    .USBWireRdyOut(rdy_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) tick();
  endtask

  task automatic drain();
    req = 4'b0000;
    cyc(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Monitor: every fresh grant must match the next queued owner and route its signals.
  always @(negedge clk) begin
    if (gnt != 4'b0000 && gnt != prev_gnt) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_unexpected: got gnt %b expected no grant at %0t", gnt, $time);
      end else begin
        ei    = sb_q.pop_front();
        exp_g = 4'b0001 << ei;
        chk("sb_gnt", 32'(gnt), 32'(exp_g));
        chk("sb_gntIdx", 32'(gntIdx), 32'(ei));
        chk("sb_TxBits", 32'(txbits), 32'(td[ei]));
        chk("sb_TxCtl", 32'(txctl), 32'(tctl[ei]));
        chk("sb_TxFSRate", 32'(txfs), 32'(tfs[ei]));
        chk("sb_WEn", 32'(wen), 32'(twen[ei]));
      end
    end
    prev_gnt = gnt;
  end

  initial begin
    rst = 1'b1; req = 4'b0000; req_b = 4'b0000; rdy_in = 1'b1;
    td[0] = 2'b01; td[1] = 2'b10; td[2] = 2'b11; td[3] = 2'b01;
    tctl = 4'b1010; tfs = 4'b0110; twen = 4'b1011;
    ord[0] = 2'd0; ord[1] = 2'd1; ord[2] = 2'd3; ord[3] = 2'd0;
    cyc(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);
    chk("rst_TxBits", 32'(txbits), 32'd0);
    chk("rst_WEn", 32'(wen), 32'd0);
    chk("rst_rrPtr", 32'(dut.rrPtr_q), 32'd3);
    chk("rdy_pass", 32'(rdy_out), 32'd1);
    rst = 1'b0;
    tick();

    // Basic grant, two-cycle gap, then hand-over to requester 1.
    req = 4'b0011; sb_q.push_back(2'd0);
    tick();
    chk("t1_latency", 32'(gnt), 32'b0001);
    cyc(2);
    req = 4'b0010; sb_q.push_back(2'd1);
    tick();
    chk("t1_gap0", 32'(gnt), 32'd0);
    chk("t1_gap0_busy", 32'(busy), 32'd1);
    chk("t1_gap0_WEn", 32'(wen), 32'd0);
    tick();
    chk("t1_gap1", 32'(gnt), 32'd0);
    tick();
    chk("t1_regrant", 32'(gnt), 32'b0010);
    chk("t1_mux", 32'(txbits), 32'b10);
    chk("t1_idx_hold", 32'(gntIdx), 32'd1);
    drain();
    chk("t1_idx_after", 32'(gntIdx), 32'd1);

    // Round-robin rotation 0,1,3,0 with drop/re-raise during the gap.
    do_reset();
    req = 4'b1011;
    for (int k = 0; k < 4; k++) sb_q.push_back(ord[k]);
    tick();
    chk("t2_first", 32'(gnt), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      cyc(4);
      req[ord[k]] = 1'b0;
      tick();
      req[ord[k]] = 1'b1;
      tick();
      tick();
      exp_g = 4'b0001 << ord[k+1];
      chk("t2_order", 32'(gnt), 32'(exp_g));
      chk("t2_rrPtr", 32'(dut.rrPtr_q), 32'(ord[k+1]));
    end
    drain();

    // No preemption; priority class served first after the gap.
    req = 4'b0001; sb_q.push_back(2'd0);
    tick();
    req = 4'b0111;
    repeat (3) begin
      tick();
      chk("t3_nopreempt", 32'(gnt), 32'b0001);
    end
    sb_q.push_back(2'd2); sb_q.push_back(2'd1);
    req = 4'b0110;
    cyc(3);
    chk("t3_hipri", 32'(gnt), 32'b0100);
    tick();
    req = 4'b0010;
    cyc(3);
    chk("t3_rr", 32'(gnt), 32'b0010);
    chk("t3_rrPtr", 32'(dut.rrPtr_q), 32'd1);
    drain();

    // Watchdog revoke after 8 cycles, lockout until req drops.
    req = 4'b0010; sb_q.push_back(2'd1);
    tick();
    chk("t4_grant", 32'(gnt), 32'b0010);
    repeat (7) begin
      tick();
      chk("t4_hold", 32'(gnt), 32'b0010);
      chk("t4_no_tmo", 32'(tmo), 32'd0);
    end
    req = 4'b1010; sb_q.push_back(2'd3);
    tick();
    chk("t4_revoke", 32'(gnt), 32'd0);
    chk("t4_tmo", 32'(tmo), 32'd1);
    tick();
    chk("t4_tmo_once", 32'(tmo), 32'd0);
    tick();
    chk("t4_r3", 32'(gnt), 32'b1000);
    cyc(2);
    req = 4'b0010;
    cyc(2);
    repeat (3) begin
      tick();
      chk("t4_locked", 32'(gnt), 32'd0);
    end
    req = 4'b0000;
    tick();
    req = 4'b0010; sb_q.push_back(2'd1);
    tick();
    chk("t4_unlock", 32'(gnt), 32'b0010);
    drain();

    // Async reset between edges clears grant and wire at once.
    req = 4'b1001; sb_q.push_back(2'd3);
    tick();
    chk("t5_grant", 32'(gnt), 32'b1000);
    chk("t5_wen_on", 32'(wen), 32'd1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'd0);
    chk("t5_async_WEn", 32'(wen), 32'd0);
    chk("t5_async_TxBits", 32'(txbits), 32'd0);
    tick();
    rst = 1'b0; sb_q.push_back(2'd0);
    tick();
    chk("t5_first", 32'(gnt), 32'b0001);
    drain();

    // Zero-gap build: one IDLE cycle between owners.
    chk("t6_rst", 32'(gnt_b), 32'd0);
    req_b = 4'b0011;
    tick();
    chk("t6_grant", 32'(gnt_b), 32'b0001);
    tick();
    req_b = 4'b0010;
    tick();
    chk("t6_idle", 32'(gnt_b), 32'd0);
    chk("t6_busy", 32'(busy_b), 32'd0);
    tick();
    chk("t6_next", 32'(gnt_b), 32'b0010);
    chk("t6_mux", 32'(txbits_b), 32'b10);
    req_b = 4'b0000;
    tick();

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
